// File: rtl/reminder_alarm.sv
// Usage-hours reminder: blinks an LED and buzzer while time_out is high, and
// takes a debounced acknowledge that pulses hand_clean to clear the counter.
module reminder_alarm #(
    parameter int BLINK_HALF = 50_000_000,
    parameter int DEBOUNCE   = 1_000_000,
    parameter int ACK_GUARD  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       time_out,
    input  logic       ack_btn,
    input  logic       buzz_en,
    output logic       alarm_led,
    output logic       buzzer,
    output logic       hand_clean,
    output logic       alarm_active,
    output logic [7:0] ack_count
);

    localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
    localparam int DW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam int GW = $clog2(ACK_GUARD + 1);

    typedef enum logic [1:0] {IDLE, ALERT, CLEAR, WAIT_LOW} state_t;

    state_t        state, state_n;
    logic          sync1, sync2, db_level, db_prev, ack_pulse;
    logic [DW-1:0] db_cnt;
    logic [BW-1:0] blink_cnt, blink_n;
    logic [GW-1:0] guard_cnt, guard_n;
    logic          led_n;

    // Debounced level flips only after DEBOUNCE consecutive mismatching samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1   <= ack_btn;
            sync2   <= sync1;
            db_prev <= db_level;
            if (sync2 != db_level) begin
                if (db_cnt == DW'(DEBOUNCE - 1)) begin
                    db_level <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign ack_pulse = db_level & ~db_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            alarm_led <= 1'b0;
            buzzer    <= 1'b0;
            blink_cnt <= '0;
            guard_cnt <= '0;
            ack_count <= 8'd0;
        end else begin
            state     <= state_n;
            alarm_led <= led_n;
            buzzer    <= led_n & buzz_en;
            blink_cnt <= blink_n;
            guard_cnt <= guard_n;
            if (state == CLEAR && ack_count != 8'hFF)
                ack_count <= ack_count + 8'd1;
        end
    end

    always_comb begin
        state_n = state;
        led_n   = alarm_led;
        blink_n = blink_cnt;
        guard_n = guard_cnt;
        case (state)
            IDLE: begin
                led_n = 1'b0;
                if (time_out) begin
                    state_n = ALERT;
                    led_n   = 1'b1;
                    blink_n = '0;
                end
            end
            ALERT: begin
                // ack wins over both the external clear and a blink toggle
                if (ack_pulse) begin
                    state_n = CLEAR;
                    led_n   = 1'b0;
                end else if (!time_out) begin
                    state_n = IDLE;
                    led_n   = 1'b0;
                end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                    blink_n = '0;
                    led_n   = ~alarm_led;
                end else begin
                    blink_n = blink_cnt + BW'(1);
                end
            end
            CLEAR: begin
                state_n = WAIT_LOW;
                led_n   = 1'b0;
                guard_n = '0;
            end
            WAIT_LOW: begin
                led_n = 1'b0;
                if (!time_out) begin
                    state_n = IDLE;
                end else if (guard_cnt == GW'(ACK_GUARD - 1)) begin
                    state_n = ALERT;
                    led_n   = 1'b1;
                    blink_n = '0;
                end else begin
                    guard_n = guard_cnt + GW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                led_n   = 1'b0;
            end
        endcase
    end

    assign hand_clean   = (state == CLEAR);
    assign alarm_active = (state != IDLE);

endmodule

// File: tb/tb_reminder_alarm.sv
// Directed bench for reminder_alarm with short blink/debounce parameters;
// a tiny counter model drops time_out one cycle after each hand_clean.
module tb_reminder_alarm;

    logic       clk = 1'b0;
    logic       reset, time_out, ack_btn, buzz_en;
    logic       alarm_led, buzzer, hand_clean, alarm_active;
    logic [7:0] ack_count;

    int errors = 0;
    int checks = 0;
    int hc_count = 0;
    bit auto_clr = 1'b0;
    bit clr_pending = 1'b0;

    reminder_alarm #(.BLINK_HALF(4), .DEBOUNCE(3), .ACK_GUARD(4)) dut (
        .clk(clk), .reset(reset), .time_out(time_out), .ack_btn(ack_btn),
        .buzz_en(buzz_en), .alarm_led(alarm_led), .buzzer(buzzer),
        .hand_clean(hand_clean), .alarm_active(alarm_active), .ack_count(ack_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are observed 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (clr_pending) begin
            time_out    = 1'b0;
            clr_pending = 1'b0;
        end
        if (hand_clean) begin
            hc_count++;
            if (auto_clr) clr_pending = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0; time_out = 1'b0; ack_btn = 1'b0; buzz_en = 1'b1;
        #1;
        check("rst_led", {7'd0, alarm_led}, 8'd0);
        check("rst_buzzer", {7'd0, buzzer}, 8'd0);
        check("rst_hand_clean", {7'd0, hand_clean}, 8'd0);
        check("rst_active", {7'd0, alarm_active}, 8'd0);
        check("rst_count", ack_count, 8'd0);
        repeat (2) step();
        reset = 1'b1;

        // basic alarm: time_out rises in cycle 10
        repeat (10) step();
        time_out = 1'b1;
        check("idle_c10", {7'd0, alarm_active}, 8'd0);
        step();
        check("active_c11", {7'd0, alarm_active}, 8'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("blink_led_c%0d", 11 + i), {7'd0, alarm_led}, (i < 4) ? 8'd1 : 8'd0);
            check($sformatf("blink_buz_c%0d", 11 + i), {7'd0, buzzer}, (i < 4) ? 8'd1 : 8'd0);
            step();
        end

        // bouncing ack: 6 toggling cycles, then 5 cycles held high
        auto_clr = 1'b1;
        hc_count = 0;
        for (int i = 0; i < 6; i++) begin
            ack_btn = (i % 2 == 0);
            step();
        end
        ack_btn = 1'b1;
        repeat (5) step();
        ack_btn = 1'b0;
        check("bounce_pre_hc", {7'd0, hand_clean}, 8'd0);
        check("bounce_pre_active", {7'd0, alarm_active}, 8'd1);
        step();
        check("bounce_hc", {7'd0, hand_clean}, 8'd1);
        check("bounce_clear_led", {7'd0, alarm_led}, 8'd0);
        check("bounce_count_pre", ack_count, 8'd0);
        step();
        check("bounce_hc_once", {7'd0, hand_clean}, 8'd0);
        check("bounce_count", ack_count, 8'd1);
        check("bounce_waitlow", {7'd0, alarm_active}, 8'd1);
        step();
        check("bounce_idle", {7'd0, alarm_active}, 8'd0);
        repeat (6) step();
        check("bounce_hc_total", hc_count[7:0], 8'd1);

        // held button across two alarms
        hc_count = 0;
        time_out = 1'b1;
        step();
        ack_btn = 1'b1;
        repeat (10) step();
        check("held_hc1", hc_count[7:0], 8'd1);
        check("held_idle1", {7'd0, alarm_active}, 8'd0);
        time_out = 1'b1;
        step();
        check("held_alert2", {7'd0, alarm_active}, 8'd1);
        repeat (89) step();
        ack_btn = 1'b0;
        check("held_still_alert", {7'd0, alarm_active}, 8'd1);
        check("held_hc_still1", hc_count[7:0], 8'd1);
        repeat (6) step();
        check("release_alert", {7'd0, alarm_active}, 8'd1);
        ack_btn = 1'b1;
        repeat (6) step();
        check("repress_hc", {7'd0, hand_clean}, 8'd1);
        check("repress_hc_total", hc_count[7:0], 8'd2);
        ack_btn = 1'b0;
        repeat (3) step();
        check("repress_idle", {7'd0, alarm_active}, 8'd0);
        check("repress_count", ack_count, 8'd3);

        // guard expiry: time_out never drops after hand_clean
        auto_clr = 1'b0;
        repeat (6) step();
        time_out = 1'b1;
        step();
        ack_btn = 1'b1;
        repeat (6) step();
        check("guard_hc", {7'd0, hand_clean}, 8'd1);
        ack_btn = 1'b0;
        step();
        check("guard_wl_active", {7'd0, alarm_active}, 8'd1);
        check("guard_wl_led", {7'd0, alarm_led}, 8'd0);
        check("guard_count", ack_count, 8'd4);
        repeat (3) step();
        check("guard_w3_led", {7'd0, alarm_led}, 8'd0);
        check("guard_w3_hc", {7'd0, hand_clean}, 8'd0);
        step();
        check("guard_realert_led", {7'd0, alarm_led}, 8'd1);
        check("guard_realert_active", {7'd0, alarm_active}, 8'd1);

        // buzz_en low: LED keeps blinking, buzzer silent
        buzz_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("mute_led_%0d", i), {7'd0, alarm_led}, (i < 4 || i == 8) ? 8'd1 : 8'd0);
            check($sformatf("mute_buz_%0d", i), {7'd0, buzzer}, 8'd0);
        end
        buzz_en = 1'b1;

        // saturation: 260 more acknowledged alarms on top of the 4 so far
        auto_clr = 1'b1;
        for (int n = 0; n < 260; n++) begin
            time_out = 1'b1;
            step();
            ack_btn = 1'b1;
            repeat (6) step();
            ack_btn = 1'b0;
            repeat (8) step();
        end
        check("sat_count", ack_count, 8'd255);
        check("sat_idle", {7'd0, alarm_active}, 8'd0);

        // reset in the middle of an alarm
        auto_clr = 1'b0;
        time_out = 1'b1;
        step();
        check("prerst_led", {7'd0, alarm_led}, 8'd1);
        reset = 1'b0;
        #1;
        check("midrst_led", {7'd0, alarm_led}, 8'd0);
        check("midrst_buzzer", {7'd0, buzzer}, 8'd0);
        check("midrst_hc", {7'd0, hand_clean}, 8'd0);
        check("midrst_active", {7'd0, alarm_active}, 8'd0);
        check("midrst_count", ack_count, 8'd0);
        step();
        check("inrst_active", {7'd0, alarm_active}, 8'd0);
        reset = 1'b1;
        step();
        check("postrst_active", {7'd0, alarm_active}, 8'd1);
        check("postrst_led", {7'd0, alarm_led}, 8'd1);
        check("postrst_count", ack_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reminder_alarm.md
REMINDER_ALARM -- requirements
Module: reminder_alarm

Interface
REQ-001 The block SHALL have parameter BLINK_HALF, default 50_000_000, meaning clk cycles per LED half-period (0.5 s at 100 MHz); legal range 2 or more.
REQ-002 The block SHALL have parameter DEBOUNCE, default 1_000_000, meaning consecutive stable synchronized samples needed to accept a button level change; legal range 2 or more.
REQ-003 The block SHALL have parameter ACK_GUARD, default 4, meaning max WAIT_LOW cycles before time_out deassertion is declared failed.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low.
REQ-006 The block SHALL have port time_out, input, 1 bit: level from the usage-hours counter; high while usage is at or above the reminder threshold.
REQ-007 The block SHALL have port ack_btn, input, 1 bit: raw, asynchronous, bouncing user acknowledge button, active-high.
REQ-008 The block SHALL have port buzz_en, input, 1 bit: buzzer enable; the LED is unaffected by it.
REQ-009 The block SHALL have port alarm_led, output, 1 bit: blinking reminder indicator.
REQ-010 The block SHALL have port buzzer, output, 1 bit: audible drive.
REQ-011 The block SHALL have port hand_clean, output, 1 bit: one-cycle pulse to the counter's manual-clear input.
REQ-012 The block SHALL have port alarm_active, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port ack_count, output, 8 bits: number of acknowledged alarms, saturating at 255.

Function
REQ-014 ack_btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 The debounced level SHALL change only after the synchronized value differs from it for DEBOUNCE consecutive cycles; any intervening mismatch-free cycle SHALL restart the count.
REQ-016 ack_pulse SHALL be a one-cycle internal strobe on each 0->1 transition of the debounced level; a held button SHALL yield exactly one strobe.
REQ-017 The FSM SHALL have states IDLE, ALERT, CLEAR and WAIT_LOW, all registered.
REQ-018 IDLE -> ALERT on the cycle after time_out is sampled high; ack_pulse in IDLE SHALL be ignored.
REQ-019 On ALERT entry, alarm_led SHALL be 1 and the blink counter SHALL be 0.
REQ-020 In ALERT, alarm_led SHALL toggle when the blink counter reaches BLINK_HALF-1, after which the counter wraps to 0; the period is therefore exactly 2*BLINK_HALF cycles.
REQ-021 ALERT -> CLEAR on ack_pulse; ack_pulse SHALL take priority over blink toggling in the same cycle.
REQ-022 ALERT -> IDLE if time_out is sampled low without an ack (external clear); ack_count SHALL be unchanged.
REQ-023 In CLEAR, hand_clean SHALL be 1 for exactly that one cycle and ack_count SHALL increment (saturating); then CLEAR -> WAIT_LOW unconditionally.
REQ-024 In WAIT_LOW, time_out sampled low SHALL go to IDLE.
REQ-025 If time_out stays high for ACK_GUARD WAIT_LOW cycles, WAIT_LOW -> ALERT, with blink restarting per REQ-019.
REQ-026 alarm_led SHALL be 0 in IDLE, CLEAR and WAIT_LOW.
REQ-027 buzzer SHALL equal alarm_led AND buzz_en, registered so it is cycle-aligned with alarm_led.
REQ-028 hand_clean SHALL be 0 in all states other than CLEAR.

Reset
REQ-029 While reset is 0, all of the following SHALL hold immediately and asynchronously: state=IDLE; alarm_led=0; buzzer=0; hand_clean=0; alarm_active=0; ack_count=0; blink and debounce counters 0; synchronizer flops and debounced level 0.
REQ-030 After reset deassertion mid-alarm, the block SHALL re-enter ALERT only through REQ-018.

Verification
REQ-031 The bench SHALL cover the basic alarm (BLINK_HALF=4, DEBOUNCE=3): time_out 0->1 at cycle 10 -> alarm_active=1 at cycle 11; alarm_led 1 for cycles 11-14 and 0 for cycles 15-18; buzzer follows alarm_led with buzz_en=1.
REQ-032 The bench SHALL cover a bouncing ack: ack_btn toggles every cycle for 6 cycles, then is held high for 5 cycles -> exactly one hand_clean pulse; ack_count=1; counter model drops time_out 1 cycle later -> IDLE.
REQ-033 The bench SHALL cover a held button: ack_btn held high for 100 cycles across two alarms -> exactly one hand_clean; the second alarm stays in ALERT until release and re-press.
REQ-034 The bench SHALL cover guard expiry (ACK_GUARD=4): time_out held high after hand_clean -> return to ALERT exactly 4 cycles after WAIT_LOW entry, alarm_led=1.
REQ-035 The bench SHALL cover buzz_en and saturation: buzz_en=0 during ALERT -> buzzer=0 while alarm_led blinks; 256 acknowledged alarms -> ack_count=255.
REQ-036 The bench SHALL cover reset mid-ALERT: reset=0 while alarm_led=1 -> all outputs 0 within the same cycle; after reset=1 with time_out=1 -> ALERT one cycle later, ack_count=0.
